// File: rtl/uart_port_controller_pkg.sv
// rtl/uart_port_controller_pkg.sv - shared types and constants for the CPLD UART port controller
//
// Purpose: FSM state encoding, host register addresses and status bit
// positions shared by the controller, its FIFO and the bench.
// Ports: none (package).

package uart_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_PULSE,
    ST_WR_WAIT_TBRE,
    ST_WR_WAIT_TSRE,
    ST_RD_PULSE,
    ST_RD_LATCH
  } state_e;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STAT_TX_READY = 0;
  localparam int STAT_RX_AVAIL = 1;

  function automatic logic [15:0] pack_status(input logic rx_avail, input logic tx_ready);
    logic [15:0] s;
    s                = '0;
    s[STAT_TX_READY] = tx_ready;
    s[STAT_RX_AVAIL] = rx_avail;
    return s;
  endfunction

endpackage

// File: rtl/uart_port_controller_if.sv
// rtl/uart_port_controller_if.sv - host request/acknowledge interface of the UART port controller
//
// Purpose: groups the single-word host handshake coming from the memory wrapper.
// Signals: req (level, held until ack), req_write, req_addr (0 data, 1 status),
//          wdata[7:0] (byte to send), ack (one-cycle pulse), rdata[15:0] (valid with ack).
// Modports: master = host side, slave = controller side.

interface uart_port_controller_if;
  logic        req;
  logic        req_write;
  logic        req_addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [15:0] rdata;

  modport master (
    output req, req_write, req_addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, req_write, req_addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - small synchronous byte FIFO buffering characters fetched from the CPLD
//
// Purpose: DEPTH-entry, 8-bit FIFO with first-word-fall-through head.
// Ports: clk, rst (sync, active-low), push + push_data, pop, head (current
//        oldest byte), full, empty.
// Push while full is accepted only when a pop happens in the same cycle.

module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]  mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/uart_port_controller.sv
// rtl/uart_port_controller.sv - bridges the CPU serial-port register pair to the CPLD UART strobes
//
// Purpose: turns host data/status requests into CPLD rdn/wrn sequences on the
// shared RAM1 byte bus, and autonomously polls data_ready into an RX FIFO.
// Ports: clk, rst (sync, active-low); host (uart_port_controller_if.slave);
//        tbre, tsre, data_ready (async CPLD status); bus_in, bus_out, bus_oe
//        (RAM1 data bus); rdn, wrn (CPLD strobes, active-low); ram1_en_n.

module uart_port_controller
  import uart_port_pkg::*;
#(
  parameter int WR_PULSE_CYCLES = 2,
  parameter int RD_PULSE_CYCLES = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_port_controller_if.slave  host,
  input  logic                   tbre,
  input  logic                   tsre,
  input  logic                   data_ready,
  input  logic [7:0]             bus_in,
  output logic [7:0]             bus_out,
  output logic                   bus_oe,
  output logic                   rdn,
  output logic                   wrn,
  output logic                   ram1_en_n
);

  localparam int CNT_MAX = (WR_PULSE_CYCLES > RD_PULSE_CYCLES) ? WR_PULSE_CYCLES : RD_PULSE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    bus_out_q, bus_out_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rdn_q, rdn_d;
  logic          wrn_q, wrn_d;
  logic          bus_oe_q, bus_oe_d;
  logic          ram1_en_n_q, ram1_en_n_d;
  logic          ack_q, ack_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          req_blocked_q, req_blocked_d;

  logic [1:0]    tbre_sync_q, tsre_sync_q, dr_sync_q;
  logic          tbre_s, tsre_s, data_ready_s;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;

  logic          host_new, is_data_wr, quick_acc, wr_req, rd_data;
  logic          rx_poll, tx_ready, wr_done;

  assign tbre_s       = tbre_sync_q[1];
  assign tsre_s       = tsre_sync_q[1];
  assign data_ready_s = dr_sync_q[1];

  // A request that has already been acknowledged stays blocked until the
  // host drops req, so a lingering level is never served twice.
  assign host_new      = host.req & ~req_blocked_q;
  assign is_data_wr    = host.req_write & (host.req_addr == ADDR_DATA);
  // Everything except a data write completes in one cycle, whatever the FSM is doing.
  assign quick_acc     = host_new & ~is_data_wr;
  assign wr_req        = host_new & is_data_wr;
  assign rd_data       = quick_acc & ~host.req_write & (host.req_addr == ADDR_DATA);
  assign fifo_pop      = rd_data & ~fifo_empty;
  assign rx_poll       = data_ready_s & ~fifo_full;
  assign tx_ready      = (state_q == ST_IDLE) & tbre_s & tsre_s;
  assign ack_d         = quick_acc | wr_done;
  assign req_blocked_d = ack_d | (req_blocked_q & host.req);

  always_comb begin
    rdata_d = '0;
    if (quick_acc && !host.req_write) begin
      if (host.req_addr == ADDR_STATUS) begin
        rdata_d = pack_status(~fifo_empty, tx_ready);
      end else if (!fifo_empty) begin
        rdata_d = {8'h00, fifo_head};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_out_d = bus_out_q;
    rx_byte_d = rx_byte_q;
    fifo_push = 1'b0;
    wr_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // RX polling wins so incoming characters are not left waiting behind TX.
        if (rx_poll) begin
          state_d = ST_RD_PULSE;
          cnt_d   = '0;
        end else if (wr_req) begin
          state_d   = ST_WR_PULSE;
          cnt_d     = '0;
          bus_out_d = host.wdata;
        end
      end
      ST_WR_PULSE: begin
        if (cnt_q == CW'(WR_PULSE_CYCLES - 1)) begin
          state_d = ST_WR_WAIT_TBRE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WR_WAIT_TBRE: begin
        if (tbre_s) begin
          state_d = ST_WR_WAIT_TSRE;
        end
      end
      ST_WR_WAIT_TSRE: begin
        if (tsre_s) begin
          state_d = ST_IDLE;
          wr_done = 1'b1;
        end
      end
      ST_RD_PULSE: begin
        // Capture on the edge leaving the pulse, after rdn has been low the full time.
        if (cnt_q == CW'(RD_PULSE_CYCLES - 1)) begin
          state_d   = ST_RD_LATCH;
          rx_byte_d = bus_in;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RD_LATCH: begin
        fifo_push = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes are registered from the next state so the CPLD pins never glitch.
    rdn_d       = (state_d != ST_RD_PULSE);
    wrn_d       = (state_d != ST_WR_PULSE);
    bus_oe_d    = (state_d == ST_WR_PULSE);
    ram1_en_n_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bus_out_q     <= '0;
      rx_byte_q     <= '0;
      rdn_q         <= 1'b1;
      wrn_q         <= 1'b1;
      bus_oe_q      <= 1'b0;
      ram1_en_n_q   <= 1'b0;
      ack_q         <= 1'b0;
      rdata_q       <= '0;
      req_blocked_q <= 1'b0;
      tbre_sync_q   <= '0;
      tsre_sync_q   <= '0;
      dr_sync_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus_out_q     <= bus_out_d;
      rx_byte_q     <= rx_byte_d;
      rdn_q         <= rdn_d;
      wrn_q         <= wrn_d;
      bus_oe_q      <= bus_oe_d;
      ram1_en_n_q   <= ram1_en_n_d;
      ack_q         <= ack_d;
      rdata_q       <= rdata_d;
      req_blocked_q <= req_blocked_d;
      tbre_sync_q   <= {tbre_sync_q[0], tbre};
      tsre_sync_q   <= {tsre_sync_q[0], tsre};
      dr_sync_q     <= {dr_sync_q[0], data_ready};
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (rx_byte_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign host.ack   = ack_q;
  assign host.rdata = rdata_q;
  assign bus_out    = bus_out_q;
  assign bus_oe     = bus_oe_q;
  assign rdn        = rdn_q;
  assign wrn        = wrn_q;
  assign ram1_en_n  = ram1_en_n_q;

endmodule

// File: tb/tb_uart_port_controller.sv
// tb/tb_uart_port_controller.sv - self-checking bench for uart_port_controller

module tb_uart_port_controller;
  import uart_port_pkg::*;

  localparam int WRP   = 2;
  localparam int RDP   = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tbre, tsre, data_ready;
  logic [7:0] bus_in, bus_out;
  logic       bus_oe, rdn, wrn, ram1_en_n;

  uart_port_controller_if host ();

  uart_port_controller #(
    .WR_PULSE_CYCLES (WRP),
    .RD_PULSE_CYCLES (RDP),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (host),
    .tbre       (tbre),
    .tsre       (tsre),
    .data_ready (data_ready),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .rdn        (rdn),
    .wrn        (wrn),
    .ram1_en_n  (ram1_en_n)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [7:0]  cpld_q[$];   // bytes the CPLD still holds
  logic [7:0]  mdl_q[$];    // bytes expected in the controller FIFO, oldest first
  logic [7:0]  tx_q[$];     // bytes seen on completed wrn pulses
  bit          reading  = 0;
  bit          tx_bad   = 0;
  logic [7:0]  tx_byte;
  logic        prev_rdn = 1'b1;
  int          wr_low = 0, last_wr_len = 0, wr_rise_cyc = 0, rdn_fall_cyc = 0;
  int          ack_cnt = 0, ack_cyc = 0;
  logic [15:0] ack_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: sample just after the edge, then update the CPLD and TX observers.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (host.ack) begin
      ack_cnt++;
      ack_rdata = host.rdata;
      ack_cyc   = cyc;
    end
    if (!wrn) begin
      if (wr_low == 0) tx_byte = bus_out;
      else if (bus_out !== tx_byte) tx_bad = 1;
      if (!bus_oe) tx_bad = 1;
      wr_low++;
    end else begin
      if (bus_oe) tx_bad = 1;
      if (wr_low > 0) begin
        tx_q.push_back(tx_byte);
        last_wr_len = wr_low;
        wr_rise_cyc = cyc;
        wr_low      = 0;
      end
    end
    if (!rdn && prev_rdn) rdn_fall_cyc = cyc;
    prev_rdn = rdn;
    if (!rdn && !reading) reading = 1;
    else if (rdn && reading) begin
      reading = 0;
      if (cpld_q.size() > 0) mdl_q.push_back(cpld_q.pop_front());
    end
    data_ready = !reading && (cpld_q.size() > 0);
    bus_in     = (cpld_q.size() > 0) ? cpld_q[0] : 8'hEE;
  endtask

  task automatic start_req(input bit w, input bit a, input logic [7:0] d);
    host.req       = 1'b1;
    host.req_write = w;
    host.req_addr  = a;
    host.wdata     = d;
  endtask

  task automatic wait_ack(input string tag, output int lat);
    int c0 = cyc;
    int n0 = ack_cnt;
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (ack_cnt != n0) ok = 1;
    end
    lat = cyc - c0;
    check({"ack_", tag}, 32'(ok), 32'd1);
  endtask

  task automatic end_req();
    host.req = 1'b0;
    tick();
  endtask

  task automatic settle();
    int quiet = 0;
    for (int i = 0; i < 400 && quiet < 6; i++) begin
      tick();
      if (rdn && !reading && !(cpld_q.size() > 0 && mdl_q.size() < DEPTH)) quiet++;
      else quiet = 0;
    end
    check("settle", 32'(quiet >= 6), 32'd1);
  endtask

  task automatic read_data(input string tag);
    int          lat;
    logic [15:0] exp;
    start_req(1'b0, ADDR_DATA, 8'h00);
    wait_ack(tag, lat);
    exp = (mdl_q.size() > 0) ? {8'h00, mdl_q.pop_front()} : 16'h0000;
    check(tag, 32'(ack_rdata), 32'(exp));
    check({tag, "_lat"}, 32'(lat), 32'd1);
    end_req();
  endtask

  task automatic read_status(input string tag, input bit exp_tx);
    int lat;
    start_req(1'b0, ADDR_STATUS, 8'h00);
    wait_ack(tag, lat);
    check(tag, 32'(ack_rdata), {30'd0, mdl_q.size() != 0, exp_tx});
    end_req();
  endtask

  task automatic write_data(input string tag, input logic [7:0] d);
    int lat;
    tx_q.delete();
    tx_bad = 0;
    start_req(1'b1, ADDR_DATA, d);
    wait_ack(tag, lat);
    end_req();
    check({tag, "_npulse"}, 32'(tx_q.size()), 32'd1);
    if (tx_q.size() > 0) check({tag, "_byte"}, 32'(tx_q[0]), 32'(d));
    check({tag, "_wrn_len"}, 32'(last_wr_len), 32'(WRP));
    check({tag, "_bus_ok"}, 32'(tx_bad), 32'd0);
    check({tag, "_ack_gap"}, 32'((ack_cyc - wr_rise_cyc) >= 2 && (ack_cyc - wr_rise_cyc) <= 3), 32'd1);
  endtask

  initial begin
    int lat, n, lows, c0;
    rst = 1'b0; tbre = 1'b1; tsre = 1'b1; data_ready = 1'b0; bus_in = 8'h00;
    host.req = 1'b0; host.req_write = 1'b0; host.req_addr = 1'b0; host.wdata = 8'h00;
    tick(); tick();
    check("rst_rdn", 32'(rdn), 32'd1);
    check("rst_wrn", 32'(wrn), 32'd1);
    check("rst_bus_oe", 32'(bus_oe), 32'd0);
    check("rst_bus_out", 32'(bus_out), 32'd0);
    check("rst_ack", 32'(host.ack), 32'd0);
    check("rst_rdata", 32'(host.rdata), 32'd0);
    check("rst_ram1_en_n", 32'(ram1_en_n), 32'd0);
    rst = 1'b1;
    tick(); tick(); tick();

    write_data("wr41", 8'h41);

    // Transmitter busy: tx_ready must read 0, and the write waits for tsre.
    tsre = 1'b0;
    tick(); tick(); tick();
    read_status("stat_tsre_low", 1'b0);
    tx_q.delete();
    n = ack_cnt;
    start_req(1'b1, ADDR_DATA, 8'h55);
    repeat (10) tick();
    check("tsre_wait_noack", 32'(ack_cnt - n), 32'd0);
    check("tsre_wait_ram1", 32'(ram1_en_n), 32'd1);
    tsre = 1'b1;
    wait_ack("wr55", lat);
    end_req();
    check("wr55_byte", 32'((tx_q.size() == 1) ? tx_q[0] : 8'h00), 32'h55);
    read_status("stat_after_wr", 1'b1);

    // Three received bytes, read back in order, then an empty read.
    cpld_q.push_back(8'h31); cpld_q.push_back(8'h32); cpld_q.push_back(8'h33);
    settle();
    check("rx3_fetched", 32'(mdl_q.size()), 32'd3);
    read_data("rx_a"); read_data("rx_b"); read_data("rx_c"); read_data("rx_empty");
    read_status("stat_rx_empty", 1'b1);

    // Overflow: the fifth byte stays in the CPLD until a slot frees up.
    for (int i = 0; i < 5; i++) cpld_q.push_back(8'(8'hA0 + i));
    settle();
    check("full_count", 32'(mdl_q.size()), 32'(DEPTH));
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!rdn) lows++;
    end
    check("full_rdn_high", 32'(lows), 32'd0);
    check("full_dr_held", 32'(data_ready), 32'd1);
    c0 = cyc;
    read_data("full_pop");
    for (int i = 0; i < 4 && rdn_fall_cyc <= c0; i++) tick();
    check("refill_latency", 32'(rdn_fall_cyc > c0 && (rdn_fall_cyc - c0) <= 4), 32'd1);
    settle();
    for (int i = 0; i < DEPTH + 1; i++) read_data("full_drain");

    // Host pop on the same edge as the FIFO push from RD_LATCH.
    cpld_q.push_back(8'h61); cpld_q.push_back(8'h62);
    settle();
    cpld_q.push_back(8'h63);
    for (int i = 0; i < 50 && rdn; i++) tick();
    for (int i = 0; i < 50 && !rdn; i++) tick();
    read_data("pushpop_head");
    settle();
    read_status("pushpop_stat", 1'b1);
    read_data("pushpop_1"); read_data("pushpop_2"); read_data("pushpop_empty");

    // Reset in the middle of a write pulse.
    n = ack_cnt;
    start_req(1'b1, ADDR_DATA, 8'h77);
    tick();
    check("midrst_wrn_low", 32'(wrn), 32'd0);
    rst = 1'b0;
    tick();
    check("midrst_wrn", 32'(wrn), 32'd1);
    check("midrst_bus_oe", 32'(bus_oe), 32'd0);
    host.req = 1'b0;
    rst = 1'b1;
    mdl_q.delete();
    repeat (4) tick();
    check("midrst_noack", 32'(ack_cnt - n), 32'd0);
    read_status("midrst_stat", 1'b1);

    // Randomized mix of traffic against the queue model.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          int k = $urandom_range(1, 3);
          for (int j = 0; j < k; j++) cpld_q.push_back(8'($urandom));
        end
        1: read_data("rnd_data");
        2: read_status("rnd_stat", 1'b1);
        3: write_data("rnd_wr", 8'($urandom));
        default: begin
          tx_q.delete();
          start_req(1'b1, ADDR_STATUS, 8'($urandom));
          wait_ack("rnd_stwr", lat);
          end_req();
          check("rnd_stwr_lat", 32'(lat), 32'd1);
          check("rnd_stwr_nobus", 32'(tx_q.size()), 32'd0);
        end
      endcase
      settle();
    end
    while (mdl_q.size() > 0 || cpld_q.size() > 0) begin
      read_data("drain");
      settle();
    end
    read_status("final_stat", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_port_controller.md
# uart_port_controller

Bridges the CPU's memory-mapped serial port to the CPLD UART on the shared 8-bit RAM1 data bus. Sits directly downstream of the memory wrapper. It turns single-word data/status requests into CPLD `rdn`/`wrn` strobe sequences. It also polls `data_ready` on its own and buffers received bytes in a small FIFO, so characters are not lost while the CPU is stalled.

## Interface
- `WR_PULSE_CYCLES`, 2, clocks `wrn` is held low (≥1)
- `RD_PULSE_CYCLES`, 2, clocks `rdn` is held low before the bus is sampled (≥1)
- `FIFO_DEPTH`, 4, RX FIFO entries (power of 2, ≥2)

Ports:
- `clk` in 1: system clock, the same clock as the CPU memory port.
- `rst` in 1: reset. One clock; reset is synchronous and active-low.
- `req` in 1: host request, a level signal held until `ack`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 1: 0 = data register, 1 = status register.
- `wdata` in 8: byte to transmit.
- `ack` out 1: one-cycle completion pulse.
- `rdata` out 16: read result, valid while `ack`=1.
- `tbre`, `tsre`, `data_ready` in 1 each: CPLD status, asynchronous.
- `bus_in` in 8: RAM1 data bus, read side.
- `bus_out` out 8: RAM1 data bus, drive value.
- `bus_oe` out 1: tri-state enable for `bus_out`.
- `rdn`, `wrn` out 1 each: CPLD strobes, active-low.
- `ram1_en_n` out 1: RAM1 chip disable. Held at 1 while this block owns the bus.

## Operation
- `tbre`, `tsre` and `data_ready` each pass through a 2-flop synchronizer. Only the synchronized values (`*_s`) are used.
- States: IDLE, WR_PULSE, WR_WAIT_TBRE, WR_WAIT_TSRE, RD_PULSE, RD_LATCH.
- IDLE to RD_PULSE: when `data_ready_s`=1 and the FIFO is not full. This has priority over a pending host write.
- IDLE to WR_PULSE: when `req & req_write & req_addr==0` and no RX poll is due.
  - `bus_out` is loaded with `wdata`, `bus_oe`=1 and `wrn`=0.
- WR_PULSE: lasts `WR_PULSE_CYCLES` cycles. Then `wrn`=1 and `bus_oe`=0, and the FSM moves to WR_WAIT_TBRE.
- WR_WAIT_TBRE to WR_WAIT_TSRE: on `tbre_s`=1.
- WR_WAIT_TSRE to IDLE: on `tsre_s`=1, with `ack` pulsed in the same transition.
- RD_PULSE: `rdn`=0 and `bus_oe`=0 for `RD_PULSE_CYCLES` cycles, then the FSM moves to RD_LATCH.
- RD_LATCH: `bus_in` is pushed into the FIFO, `rdn`=1, and the FSM returns to IDLE.
- Host reads never touch the bus. They are served in any FSM state.
  - Status read: `rdata` = {14'b0, `fifo_nonempty`, `tx_ready`}. `tx_ready` = (state==IDLE) & `tbre_s` & `tsre_s`.
  - Data read: `rdata` = {8'b0, FIFO head}, and the FIFO pops.
  - Data read with an empty FIFO: `rdata` = 0, no pop, `ack` still pulses.
- A host write to the status address is acknowledged next cycle and otherwise ignored.
- `ram1_en_n`=1 in every state except IDLE. In IDLE it is 0.
- FIFO is full: polling stops, `rdn` stays high, and the byte is left in the CPLD. There is no overrun flag.
- Push and pop in the same cycle: both take effect, and the count is unchanged. This is legal even when the FIFO is full, because the pop frees a slot.

## Timing
- Reset values: state IDLE, FIFO empty, `rdn`=`wrn`=1, `bus_oe`=0, `bus_out`=0, `ack`=0, `rdata`=0, `ram1_en_n`=0. Synchronizers are cleared to 0.
- Host read latency: `ack` is asserted 1 cycle after `req` is sampled, and `rdata` is registered alongside it.
- After `ack`, the host must drop `req` for at least one cycle. A `req` still high on the cycle after `ack` is not treated as a new request.
- Host write latency is at least `WR_PULSE_CYCLES` + 2 synchronizer cycles + the CPLD shift time.
- RX read occupies the bus for `RD_PULSE_CYCLES` + 1 cycles.
- `bus_in` is sampled on the edge that leaves RD_PULSE, i.e. after `rdn` has been low for `RD_PULSE_CYCLES` full cycles.
- `bus_out` is stable for the whole time `wrn` is low, and `bus_oe` is deasserted in the same cycle `wrn` rises.
- Reset mid-operation: all strobes return high on the first reset edge and the FIFO is cleared. A write in progress is not acknowledged, and the transmitted byte may be corrupt.

## Structure
- Shared package `uart_port_pkg` holds:
  - the state enum;
  - `ADDR_DATA`=0 and `ADDR_STATUS`=1;
  - status bit indices `STAT_TX_READY`=0 and `STAT_RX_AVAIL`=1.
- Sub-module `uart_rx_fifo`: 8-bit wide, `FIFO_DEPTH`-entry synchronous FIFO.
  - Ports: push, pop, head, full, empty.
  - Wrap-around uses pointers one bit wider than the index.

## Test plan
- Write 0x41 with `tbre`/`tsre` tied high:
  - `wrn` low for exactly 2 cycles with `bus_out`=0x41 and `bus_oe`=1;
  - `ack` arrives once the synchronized `tsre` is seen, 2–3 cycles later.
- Status read while a write waits for `tsre`=0 → `rdata`=0x0000. After `tsre` rises and the write acks, status read → 0x0001.
- Pulse `data_ready` for bytes 0x31, 0x32, 0x33, then issue 3 data reads → 0x0031, 0x0032, 0x0033. A fourth read → 0x0000, and status bit1=0.
- Send 5 bytes with `FIFO_DEPTH`=4:
  - after 4 bytes, `rdn` stays high and `data_ready` is held;
  - one data read frees a slot, and the 5th byte is fetched within 4 cycles.
- Host data read in the same cycle as RD_LATCH, FIFO holding 2 entries → the read returns the old head, and the count stays at 2.
- Assert `rst`=0 during WR_PULSE → next edge `wrn`=1, `bus_oe`=0, no `ack`. After release, status read → 0x0001 with `tbre`/`tsre` high.
